// File: rtl/tournament_predictor.sv
// tournament_predictor
//   Tournament branch predictor: a PC-indexed local table and a gshare
//   global table, each entry holding {valid, tag, ctr, target}, plus a 2-bit
//   chooser per local index. The history used at fetch is exported per slot
//   and comes back with the branch at resolution, so the update indexes gshare
//   exactly as fetch did.
//
//   Ports
//     clock, reset        : single clock; synchronous active-high reset
//     fetch_EN/fetch_pc   : per-slot lookups, slot 0 oldest
//     predict_found       : hit in the table the chooser selected
//     predict_direction   : predicted taken (only when found)
//     predict_pc          : predicted target, 0 unless found and taken
//     predict_hist        : speculative history used for this lookup
//     update_*            : one resolved branch per cycle, qualified by update_EN
//     lookup_cnt          : saturating count of enabled, found lookups
//     mispredict_cnt      : saturating count of mispredicted updates
//
//   Handshake: there is no backpressure. fetch_EN[s] and update_EN are plain
//   valid qualifiers sampled every cycle; a high enable means "consume this
//   slot's inputs now".
`ifndef XLEN
`define XLEN 32
`endif

module tournament_predictor #(
  parameter int FETCH_W = 3,
  parameter int IDX_W   = 6,
  parameter int HIST_W  = 6,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = `XLEN - IDX_W - 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [FETCH_W-1:0]               fetch_EN,
  input  logic [FETCH_W-1:0][`XLEN-1:0]    fetch_pc,
  output logic [FETCH_W-1:0]               predict_found,
  output logic [FETCH_W-1:0]               predict_direction,
  output logic [FETCH_W-1:0][`XLEN-1:0]    predict_pc,
  output logic [FETCH_W-1:0][HIST_W-1:0]   predict_hist,
  input  logic                             update_EN,
  input  logic [`XLEN-1:0]                 update_pc,
  input  logic                             update_direction,
  input  logic [`XLEN-1:0]                 update_target,
  input  logic [HIST_W-1:0]                update_hist,
  input  logic                             update_mispredict,
  output logic [31:0]                      lookup_cnt,
  output logic [31:0]                      mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  // Allocation values: weakest state on the side of the observed outcome.
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

  // Local table
  logic                l_valid  [ENTRIES];
  logic [TAG_W-1:0]    l_tag    [ENTRIES];
  logic [CTR_W-1:0]    l_ctr    [ENTRIES];
  logic [`XLEN-1:0]    l_target [ENTRIES];
  // Global (gshare) table
  logic                g_valid  [ENTRIES];
  logic [TAG_W-1:0]    g_tag    [ENTRIES];
  logic [CTR_W-1:0]    g_ctr    [ENTRIES];
  logic [`XLEN-1:0]    g_target [ENTRIES];
  // Chooser: MSB set selects the global table
  logic [1:0]          chooser  [ENTRIES];

  logic [HIST_W-1:0]   spec_ghr;

  // ---------------------------------------------------------------- lookup
  for (genvar s = 0; s < FETCH_W; s++) begin : g_slot
    logic [IDX_W-1:0] li;
    logic [IDX_W-1:0] gi;
    logic [TAG_W-1:0] tg;
    logic             use_g;
    logic             hit;
    logic             taken;
    logic [`XLEN-1:0] tgt;
    logic             unused_pc_bits;

    assign li    = fetch_pc[s][2 +: IDX_W];
    assign gi    = li ^ IDX_W'(spec_ghr);
    assign tg    = fetch_pc[s][`XLEN-1:IDX_W+2];
    assign use_g = chooser[li][1];
    // Only the selected table may produce a hit.
    assign hit   = use_g ? (g_valid[gi] && (g_tag[gi] == tg))
                         : (l_valid[li] && (l_tag[li] == tg));
    assign taken = use_g ? g_ctr[gi][CTR_W-1] : l_ctr[li][CTR_W-1];
    assign tgt   = use_g ? g_target[gi] : l_target[li];

    assign predict_found[s]     = hit;
    assign predict_direction[s] = hit && taken;
    assign predict_pc[s]        = (hit && taken) ? tgt : '0;
    assign predict_hist[s]      = spec_ghr;
    assign unused_pc_bits       = ^fetch_pc[s][1:0];
  end

  // Speculative history: shift predicted directions oldest first, stopping
  // after the first predicted-taken slot (younger slots get redirected away).
  logic [HIST_W-1:0] ghr_shift;
  logic              shift_stop;
  always_comb begin
    ghr_shift  = spec_ghr;
    shift_stop = 1'b0;
    for (int s = 0; s < FETCH_W; s++) begin
      if (!shift_stop && fetch_EN[s] && predict_found[s]) begin
        ghr_shift  = {ghr_shift[HIST_W-2:0], predict_direction[s]};
        shift_stop = predict_direction[s];
      end
    end
  end

  // Lookup count accumulates in 33 bits so an overflow can be clamped.
  logic [32:0] lookup_sum;
  always_comb begin
    lookup_sum = {1'b0, lookup_cnt};
    for (int s = 0; s < FETCH_W; s++) begin
      lookup_sum = lookup_sum + 33'(fetch_EN[s] & predict_found[s]);
    end
  end

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] u_li;
  logic [IDX_W-1:0] u_gi;
  logic [TAG_W-1:0] u_tag;
  logic             u_l_hit;
  logic             u_g_hit;
  logic             u_l_taken;
  logic             u_g_taken;
  logic             chooser_adjust;
  logic             unused_update_bits;

  assign u_li      = update_pc[2 +: IDX_W];
  assign u_gi      = u_li ^ IDX_W'(update_hist);
  assign u_tag     = update_pc[`XLEN-1:IDX_W+2];
  assign u_l_hit   = l_valid[u_li] && (l_tag[u_li] == u_tag);
  assign u_g_hit   = g_valid[u_gi] && (g_tag[u_gi] == u_tag);
  assign u_l_taken = l_ctr[u_li][CTR_W-1];
  assign u_g_taken = g_ctr[u_gi][CTR_W-1];
  // Chooser learns only when both tables had an opinion and they disagreed.
  assign chooser_adjust     = u_l_hit && u_g_hit && (u_l_taken != u_g_taken);
  assign unused_update_bits = ^update_pc[1:0];

  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c,
                                                 input logic hit,
                                                 input logic dir);
    if (!hit) return dir ? CTR_WEAK_T : CTR_WEAK_NT;
    if (dir)  return (c == '1) ? c : c + CTR_W'(1);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        l_valid[i]  <= 1'b0;
        l_tag[i]    <= '0;
        l_ctr[i]    <= '0;
        l_target[i] <= '0;
        g_valid[i]  <= 1'b0;
        g_tag[i]    <= '0;
        g_ctr[i]    <= '0;
        g_target[i] <= '0;
        chooser[i]  <= 2'b10;
      end
      spec_ghr       <= '0;
      lookup_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (update_EN) begin
        l_valid[u_li] <= 1'b1;
        l_tag[u_li]   <= u_tag;
        l_ctr[u_li]   <= ctr_train(l_ctr[u_li], u_l_hit, update_direction);
        if (!u_l_hit || update_direction) l_target[u_li] <= update_target;

        g_valid[u_gi] <= 1'b1;
        g_tag[u_gi]   <= u_tag;
        g_ctr[u_gi]   <= ctr_train(g_ctr[u_gi], u_g_hit, update_direction);
        if (!u_g_hit || update_direction) g_target[u_gi] <= update_target;

        if (chooser_adjust) begin
          if (u_g_taken == update_direction) begin
            if (chooser[u_li] != 2'b11) chooser[u_li] <= chooser[u_li] + 2'd1;
          end else begin
            if (chooser[u_li] != 2'b00) chooser[u_li] <= chooser[u_li] - 2'd1;
          end
        end
      end

      // A mispredict rebuilds history from the branch's own fetch-time
      // history and wins over any shift fetch made this cycle.
      if (update_EN && update_mispredict) begin
        spec_ghr <= {update_hist[HIST_W-2:0], update_direction};
      end else begin
        spec_ghr <= ghr_shift;
      end

      lookup_cnt <= lookup_sum[32] ? 32'hFFFF_FFFF : lookup_sum[31:0];
      if (update_EN && update_mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed bench for tournament_predictor (FETCH_W=3, IDX_W=6, HIST_W=6,
// CTR_W=2). Expected values are pushed into exp_q as each step is driven and
// popped when the corresponding DUT output is sampled.
`ifndef XLEN
`define XLEN 32
`endif

module tb_tournament_predictor;
  localparam int FETCH_W = 3;
  localparam int IDX_W   = 6;
  localparam int HIST_W  = 6;
  localparam int CTR_W   = 2;
  localparam int W       = 64;

  // ------------------------------------------------------ clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [FETCH_W-1:0]              fetch_EN;
  logic [FETCH_W-1:0][`XLEN-1:0]   fetch_pc;
  logic [FETCH_W-1:0]              predict_found;
  logic [FETCH_W-1:0]              predict_direction;
  logic [FETCH_W-1:0][`XLEN-1:0]   predict_pc;
  logic [FETCH_W-1:0][HIST_W-1:0]  predict_hist;
  logic                            update_EN;
  logic [`XLEN-1:0]                update_pc;
  logic                            update_direction;
  logic [`XLEN-1:0]                update_target;
  logic [HIST_W-1:0]               update_hist;
  logic                            update_mispredict;
  logic [31:0]                     lookup_cnt;
  logic [31:0]                     mispredict_cnt;

  tournament_predictor #(
    .FETCH_W(FETCH_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W)
  ) dut (
    .clock(clock), .reset(reset),
    .fetch_EN(fetch_EN), .fetch_pc(fetch_pc),
    .predict_found(predict_found), .predict_direction(predict_direction),
    .predict_pc(predict_pc), .predict_hist(predict_hist),
    .update_EN(update_EN), .update_pc(update_pc),
    .update_direction(update_direction), .update_target(update_target),
    .update_hist(update_hist), .update_mispredict(update_mispredict),
    .lookup_cnt(lookup_cnt), .mispredict_cnt(mispredict_cnt)
  );

  // ------------------------------------------------------ scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic expect_v(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed %0h with no expected value queued", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fetch_EN          = '0;
    for (int s = 0; s < FETCH_W; s++) fetch_pc[s] = $urandom;
    update_EN         = 1'b0;
    update_pc         = $urandom;
    update_direction  = 1'b0;
    update_target     = $urandom;
    update_hist       = HIST_W'($urandom_range(0, 63));
    update_mispredict = 1'b0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic dir,
                              input logic [31:0] tgt, input logic [5:0] hist,
                              input logic misp);
    update_EN         = 1'b1;
    update_pc         = pc;
    update_direction  = dir;
    update_target     = tgt;
    update_hist       = hist;
    update_mispredict = misp;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic dir,
                           input logic [31:0] tgt, input logic [5:0] hist,
                           input logic misp);
    drive_update(pc, dir, tgt, hist, misp);
    tick();
    idle();
  endtask

  task automatic drive_fetch(input logic [2:0] en, input logic [31:0] pc0,
                             input logic [31:0] pc1, input logic [31:0] pc2);
    fetch_EN    = en;
    fetch_pc[0] = pc0;
    fetch_pc[1] = pc1;
    fetch_pc[2] = pc2;
  endtask

  // ------------------------------------------------------ directed steps
  initial begin
    idle();
    reset = 1'b1;
    drive_fetch(3'b111, $urandom, $urandom, $urandom);
    tick();

    // Cycle after reset: everything cleared even with all slots enabled.
    reset = 1'b0;
    drive_fetch(3'b111, $urandom, $urandom, $urandom);
    expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    #1;
    check("rst_found", predict_found);
    check("rst_dir", predict_direction);
    check("rst_pc", predict_pc[0] | predict_pc[1] | predict_pc[2]);
    check("rst_hist", predict_hist);
    check("rst_lookup_cnt", lookup_cnt);
    check("rst_mispredict_cnt", mispredict_cnt);
    tick();
    idle();
    expect_v(0);
    check("rst_lookup_cnt_after_miss_fetch", lookup_cnt);

    // Allocate 0x100 taken, then train once more: ctr 10 -> 11.
    do_update(32'h100, 1'b1, 32'h200, 6'h00, 1'b0);
    do_update(32'h100, 1'b1, 32'h200, 6'h00, 1'b0);
    drive_fetch(3'b001, 32'h100, $urandom, $urandom);
    expect_v(3'b001); expect_v(3'b001); expect_v(32'h200); expect_v(6'h00);
    #1;
    check("hit_found", predict_found);
    check("hit_dir", predict_direction);
    check("hit_pc", predict_pc[0]);
    check("hit_hist", predict_hist[0]);
    tick();
    idle();
    expect_v(1); expect_v(6'h01);
    check("hit_lookup_cnt", lookup_cnt);
    check("hit_ghr_shift", predict_hist[0]);

    // Not-taken mispredict: ctr 11 -> 10 (still taken), history rebuilt to 0.
    do_update(32'h100, 1'b0, $urandom, 6'h00, 1'b1);
    expect_v(1); expect_v(6'h00);
    check("nt1_mispredict_cnt", mispredict_cnt);
    check("nt1_ghr_recover", predict_hist[2]);
    drive_fetch(3'b001, 32'h100, $urandom, $urandom);
    expect_v(3'b001); expect_v(3'b001); expect_v(32'h200);
    #1;
    check("nt1_found", predict_found);
    check("nt1_dir", predict_direction);
    check("nt1_pc", predict_pc[0]);
    tick();
    idle();

    // Second not-taken: ctr 10 -> 01, now predicted not taken, target hidden.
    do_update(32'h100, 1'b0, $urandom, 6'h00, 1'b1);
    drive_fetch(3'b001, 32'h100, $urandom, $urandom);
    expect_v(3'b001); expect_v(3'b000); expect_v(0);
    #1;
    check("nt2_found", predict_found);
    check("nt2_dir", predict_direction);
    check("nt2_pc", predict_pc[0]);
    tick();
    idle();
    expect_v(3); expect_v(2); expect_v(6'h00);
    check("nt2_lookup_cnt", lookup_cnt);
    check("nt2_mispredict_cnt", mispredict_cnt);
    check("nt2_ghr", predict_hist[1]);

    // Three-slot fetch under history 000001: NT, T, T.
    do_update(32'h10, 1'b0, $urandom,  6'h01, 1'b0);
    do_update(32'h20, 1'b1, 32'h2020,  6'h01, 1'b0);
    do_update(32'h30, 1'b1, 32'h3030,  6'h01, 1'b0);
    do_update(32'hFC, 1'b1, 32'h4040,  6'h00, 1'b1);
    expect_v(6'h01);
    check("multi_ghr_before", predict_hist[0]);
    drive_fetch(3'b111, 32'h10, 32'h20, 32'h30);
    expect_v(3'b111); expect_v(3'b110); expect_v(0); expect_v(32'h2020); expect_v(32'h3030);
    #1;
    check("multi_found", predict_found);
    check("multi_dir", predict_direction);
    check("multi_pc0", predict_pc[0]);
    check("multi_pc1", predict_pc[1]);
    check("multi_pc2", predict_pc[2]);
    tick();
    idle();
    expect_v(6'b000101); expect_v(6); expect_v(3);
    check("multi_ghr_after", predict_hist[0]);
    check("multi_lookup_cnt", lookup_cnt);
    check("multi_mispredict_cnt", mispredict_cnt);

    // Mispredict recovery in the same cycle as a taken fetch prediction.
    do_update(32'h40, 1'b1, 32'h5050, 6'h05, 1'b0);
    drive_fetch(3'b001, 32'h40, $urandom, $urandom);
    drive_update(32'hF8, 1'b1, 32'h6060, 6'b101010, 1'b1);
    expect_v(3'b001); expect_v(3'b001); expect_v(32'h5050);
    #1;
    check("recov_fetch_found", predict_found);
    check("recov_fetch_dir", predict_direction);
    check("recov_fetch_pc", predict_pc[0]);
    tick();
    idle();
    expect_v(6'b010101); expect_v(4); expect_v(7);
    check("recov_ghr", predict_hist[0]);
    check("recov_mispredict_cnt", mispredict_cnt);
    check("recov_lookup_cnt", lookup_cnt);

    // Chooser: 0x80 local taken, global entry (aliased via 0x84, hist 1) not taken.
    do_update(32'h80, 1'b1, 32'h300, 6'h00, 1'b0);
    do_update(32'h84, 1'b0, $urandom, 6'h01, 1'b0);
    drive_fetch(3'b001, 32'h80, $urandom, $urandom);
    expect_v(3'b000);
    #1;
    check("chooser10_global_sel_miss", predict_found);
    tick();
    idle();
    for (int r = 0; r < 3; r++) begin
      if (r > 0) do_update(32'h84, 1'b0, $urandom, 6'h01, 1'b0);
      do_update(32'h80, 1'b1, 32'h300, 6'h00, 1'b0);
      drive_fetch(3'b001, 32'h80, $urandom, $urandom);
      expect_v(3'b001); expect_v(3'b001); expect_v(32'h300);
      #1;
      check($sformatf("chooser_local_found_%0d", r), predict_found);
      check($sformatf("chooser_local_dir_%0d", r), predict_direction);
      check($sformatf("chooser_local_pc_%0d", r), predict_pc[0]);
      tick();
      idle();
    end
    expect_v(10); expect_v(6'h2F);
    check("chooser_lookup_cnt", lookup_cnt);
    check("chooser_ghr", predict_hist[0]);

    // Reset mid-operation beats a concurrent mispredict and fetch.
    reset = 1'b1;
    drive_fetch(3'b111, 32'h80, 32'h100, 32'h40);
    drive_update(32'hF8, 1'b1, 32'h6060, 6'b101010, 1'b1);
    tick();
    reset = 1'b0;
    idle();
    drive_fetch(3'b111, 32'h80, 32'h100, 32'h40);
    expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    #1;
    check("rst2_found", predict_found);
    check("rst2_pc", predict_pc[0] | predict_pc[1] | predict_pc[2]);
    check("rst2_hist", predict_hist);
    check("rst2_lookup_cnt", lookup_cnt);
    check("rst2_mispredict_cnt", mispredict_cnt);
    tick();
    idle();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed %0d leftover expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
